// File: rtl/tk1_spi_target_if.sv
// tk1_spi_target_if: register bus between SoC firmware and the SPI target
interface tk1_spi_target_if;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  modport master (output cs, we, address, write_data, input read_data, ready);
  modport slave (input cs, we, address, write_data, output read_data, ready);
endinterface

// File: rtl/tk1_spi_target.sv
// tk1_spi_target: mode-0 SPI target with one RX and one TX holding byte on the register bus
// Optional RX interrupt output and CTRL.irq_en bit are built only when SPI_TARGET_IRQ_EN is defined.
module tk1_spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hff
) (
  input  logic clk,
  input  logic reset,
  input  logic spi_ss,
  input  logic spi_sck,
  input  logic spi_mosi,
  output logic spi_miso,
`ifdef SPI_TARGET_IRQ_EN
  output logic irq,
`endif
  tk1_spi_target_if.slave bus
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] ss_q, sck_q, mosi_q;
  logic ss_prev, sck_prev, ss_s, sck_s, mosi_s;
  logic ss_fall, ss_rise, sck_rise, sck_fall;
  logic enable, irq_en, rx_valid, tx_full, overrun, frame_err;
  logic [2:0] bit_ctr;
  logic [7:0] rx_shift, rx_data, tx_shift, tx_hold;
  logic rd, wr, pop, reload;
  assign ss_s     = ss_q[SYNC_STAGES-1];
  assign sck_s    = sck_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  assign ss_fall  = ss_prev & ~ss_s;
  assign ss_rise  = ~ss_prev & ss_s;
  assign sck_rise = ~sck_prev & sck_s;
  assign sck_fall = sck_prev & ~sck_s;
  assign rd       = bus.cs & ~bus.we;
  assign wr       = bus.cs & bus.we;
  assign pop      = rd && bus.address == 8'h02;
  // TX reload points: frame entry and every byte boundary on the falling sck edge
  assign reload   = state == IDLE ? ss_fall & enable
                                  : enable & ~ss_rise & sck_fall & (bit_ctr == 3'd0);
  assign spi_miso = tx_shift[7];
  assign bus.ready = bus.cs;
  always_comb begin
    bus.read_data = '0;
    if (rd)
      bus.read_data = bus.address == 8'h00 ? {30'd0, irq_en, enable} :
                      bus.address == 8'h01 ? {27'd0, frame_err, overrun, state == ACTIVE, tx_full, rx_valid} :
                      bus.address == 8'h02 ? {24'd0, rx_data} : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ss_q <= '1;
      sck_q <= '0;
      mosi_q <= '0;
      ss_prev <= 1'b1;
      sck_prev <= 1'b0;
      state <= IDLE;
      enable <= 1'b0;
      rx_valid <= 1'b0;
      tx_full <= 1'b0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
      bit_ctr <= 3'd0;
      rx_shift <= 8'd0;
      rx_data <= 8'd0;
      tx_shift <= 8'hff;
      tx_hold <= 8'd0;
    end else begin
      ss_q <= {ss_q[SYNC_STAGES-2:0], spi_ss};
      sck_q <= {sck_q[SYNC_STAGES-2:0], spi_sck};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      ss_prev <= ss_s;
      sck_prev <= sck_s;
      if (wr && bus.address == 8'h00) enable <= bus.write_data[0];
      if (pop) rx_valid <= 1'b0;
      if (wr && bus.address == 8'h04) begin
        if (bus.write_data[0]) overrun <= 1'b0;
        if (bus.write_data[1]) frame_err <= 1'b0;
      end
      if (reload) begin
        tx_shift <= tx_full ? tx_hold : IDLE_BYTE;
        tx_full <= 1'b0;
      end
      if (state == IDLE) begin
        if (ss_fall && enable) begin
          state <= ACTIVE;
          bit_ctr <= 3'd0;
        end
      end else if (!enable || ss_rise) begin
        state <= IDLE;
        bit_ctr <= 3'd0;
        tx_shift <= 8'hff;
        if (enable && bit_ctr != 3'd0) frame_err <= 1'b1;
      end else begin
        if (sck_rise) begin
          rx_shift <= {rx_shift[6:0], mosi_s};
          bit_ctr <= bit_ctr + 3'd1;
          if (bit_ctr == 3'd7) begin
            rx_data <= {rx_shift[6:0], mosi_s};
            rx_valid <= 1'b1;
            if (rx_valid && !pop) overrun <= 1'b1;
          end
        end
        if (sck_fall && bit_ctr != 3'd0) tx_shift <= {tx_shift[6:0], 1'b0};
      end
      // a reload in the same cycle frees the holding byte, so the write lands
      if (wr && bus.address == 8'h03 && (!tx_full || reload)) begin
        tx_hold <= bus.write_data[7:0];
        tx_full <= 1'b1;
      end
    end
  end
`ifdef SPI_TARGET_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr && bus.address == 8'h00) irq_en <= bus.write_data[1];
      irq <= irq_en & (rx_valid | overrun | frame_err);
    end
  end
`else
  assign irq_en = 1'b0;
`endif
endmodule

// File: tb/tb_tk1_spi_target.sv
// tb_tk1_spi_target: scoreboard bench; register reads and MISO bytes are checked by monitors
module tb_tk1_spi_target;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic spi_ss = 1'b1;
  logic spi_sck = 1'b0;
  logic spi_mosi = 1'b0;
  logic spi_miso;
`ifdef SPI_TARGET_IRQ_EN
  logic irq;
`endif
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] rd_q[$];
  logic [7:0] miso_q[$];
  logic [7:0] miso_sh = 8'd0;
  int miso_n = 0;
  tk1_spi_target_if bus();
  tk1_spi_target dut (
    .clk(clk), .reset(reset), .spi_ss(spi_ss), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso),
`ifdef SPI_TARGET_IRQ_EN
    .irq(irq),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (bus.cs && !bus.we) begin
      if (rd_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL read addr %h: got %h expected nothing queued", bus.address, bus.read_data);
      end else
        check($sformatf("read addr %h", bus.address), bus.read_data, rd_q.pop_front());
      check("ready", {31'd0, bus.ready}, 32'd1);
    end
  always @(posedge spi_sck or posedge spi_ss)
    if (spi_ss) miso_n = 0;
    else begin
      miso_sh = {miso_sh[6:0], spi_miso};
      miso_n++;
      if (miso_n == 8) begin
        miso_n = 0;
        if (miso_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL miso byte: got %h expected nothing queued", miso_sh);
        end else
          check("miso byte", {24'd0, miso_sh}, {24'd0, miso_q.pop_front()});
      end
    end
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic bus_rd(input logic [7:0] a, input logic [31:0] exp);
    @(posedge clk);
    #1;
    rd_q.push_back(exp);
    bus.cs = 1'b1; bus.we = 1'b0; bus.address = a;
    wait_clk(1);
    bus.cs = 1'b0;
  endtask
  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.cs = 1'b1; bus.we = 1'b1; bus.address = a; bus.write_data = d;
    wait_clk(1);
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask
  // mode 1: pop RX_DATA in the completion cycle of this bit; mode 2: check irq timing
  task automatic send_bit(input logic b, input int mode, input logic [7:0] pop_exp);
    spi_mosi = b;
    wait_clk(8);
    spi_sck = 1'b1;
    if (mode == 1) begin
      wait_clk(2);
      rd_q.push_back({24'd0, pop_exp});
      bus.cs = 1'b1; bus.we = 1'b0; bus.address = 8'h02;
      wait_clk(1);
      bus.cs = 1'b0;
      wait_clk(5);
    end else if (mode == 2) begin
      wait_clk(3);
`ifdef SPI_TARGET_IRQ_EN
      check("irq before", {31'd0, irq}, 32'd0);
`endif
      wait_clk(1);
`ifdef SPI_TARGET_IRQ_EN
      check("irq after", {31'd0, irq}, 32'd1);
`endif
      wait_clk(4);
    end else wait_clk(8);
    spi_sck = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] d, input int mode, input logic [7:0] pop_exp);
    for (int i = 7; i >= 0; i--) send_bit(d[i], i == 0 ? mode : 0, pop_exp);
  endtask
  task automatic ss_low();
    spi_ss = 1'b0;
    wait_clk(8);
  endtask
  task automatic ss_high();
    wait_clk(8);
    spi_ss = 1'b1;
    wait_clk(8);
  endtask
  initial begin
    bus.cs = 1'b0; bus.we = 1'b0; bus.address = 8'd0; bus.write_data = 32'd0;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(2);
    check("reset miso", {31'd0, spi_miso}, 32'd1);
    check("reset ready", {31'd0, bus.ready}, 32'd0);
    check("idle read_data", bus.read_data, 32'd0);
`ifdef SPI_TARGET_IRQ_EN
    check("reset irq", {31'd0, irq}, 32'd0);
`endif
    for (int a = 0; a < 5; a++) bus_rd(a[7:0], 32'd0);
    // basic exchange
    bus_wr(8'h00, 32'h1);
    bus_wr(8'h03, 32'hA5);
    miso_q.push_back(8'hA5);
    ss_low(); send_byte(8'h3C, 0, 8'h00); ss_high();
    bus_rd(8'h01, 32'h01);
    bus_rd(8'h02, 32'h3C);
    bus_rd(8'h01, 32'h00);
    // idle byte and overrun
    miso_q.push_back(8'hFF); miso_q.push_back(8'hFF);
    ss_low(); send_byte(8'h81, 0, 8'h00); send_byte(8'h42, 0, 8'h00); ss_high();
    bus_rd(8'h01, 32'h09);
    bus_rd(8'h02, 32'h42);
    bus_wr(8'h04, 32'h1);
    bus_rd(8'h01, 32'h00);
    // truncated frame
    ss_low();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0, 8'h00);
    ss_high();
    bus_rd(8'h01, 32'h10);
    bus_wr(8'h04, 32'h2);
    bus_rd(8'h01, 32'h00);
    // pop in the completion cycle
    miso_q.push_back(8'hFF); miso_q.push_back(8'hFF);
    ss_low(); send_byte(8'h11, 0, 8'h00); send_byte(8'h22, 1, 8'h11); ss_high();
    bus_rd(8'h01, 32'h01);
    bus_rd(8'h02, 32'h22);
    bus_rd(8'h01, 32'h00);
    // second TX write while full is dropped
    bus_wr(8'h03, 32'h5A);
    bus_wr(8'h03, 32'h77);
    bus_rd(8'h01, 32'h02);
    miso_q.push_back(8'h5A);
    ss_low(); send_byte(8'h00, 0, 8'h00); ss_high();
    bus_rd(8'h02, 32'h00);
    bus_rd(8'h01, 32'h00);
    // disable mid-frame: no frame error
    ss_low();
    for (int i = 0; i < 3; i++) send_bit(1'b0, 0, 8'h00);
    bus_wr(8'h00, 32'h0);
    ss_high();
    bus_rd(8'h01, 32'h00);
    // interrupt path
    bus_wr(8'h00, 32'h3);
`ifdef SPI_TARGET_IRQ_EN
    bus_rd(8'h00, 32'h3);
`else
    bus_rd(8'h00, 32'h1);
`endif
    miso_q.push_back(8'hFF);
    ss_low(); send_byte(8'h55, 2, 8'h00); ss_high();
    bus_rd(8'h02, 32'h55);
    wait_clk(1);
`ifdef SPI_TARGET_IRQ_EN
    check("irq cleared", {31'd0, irq}, 32'd0);
`endif
    bus_rd(8'h01, 32'h00);
    wait_clk(20);
    check("read queue drained", rd_q.size(), 32'd0);
    check("miso queue drained", miso_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
